serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Sequencer that shares one 1-bit full-add datapath across all bit positions of an N-bit addition.
- The datapath is two HalfAdder instances plus an OR for the carry.
- The block captures two operands on a start pulse and feeds one bit pair per clock, LSB first, through the shared datapath.
- It keeps the carry in a flip-flop, assembles the sum in a shift register, and reports completion with a one-cycle done pulse.
- Sits between the testbench/control logic and the half-adder datapath as its scheduler.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- busy  output  1  high while an addition is in progress (RUN or DONE).
- done  output  1  one-cycle pulse; sum/cout valid from this cycle.
- sum  output  WIDTH  registered result (a+b) mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; clock port clk, reset port rst.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0; internal carry, count and shift registers are all 0.
- Reset priority: reset overrides all other inputs on the same edge.

Datapath per cycle (shared 1-bit full add):
- ha1 = HalfAdder(a_sh[0], b_sh[0]); ha2 = HalfAdder(ha1.SUM, carry).
- bit_sum = ha2.SUM; bit_carry = ha1.COUT | ha2.COUT.

FSM states:
- IDLE:
  - busy=0, done=0.
  - start=1 → load a_sh=a, b_sh=b, carry=0, count=0, res_sh=0; go to RUN.
  - start=0 → stay in IDLE.
- RUN:
  - busy=1, done=0.
  - Each edge: res_sh shifts right with bit_sum entering the MSB.
  - Each edge: a_sh and b_sh shift right, carry=bit_carry, count=count+1.
  - count==WIDTH-1 on an edge → load sum={bit_sum, res_sh[WIDTH-1:1]} and cout=bit_carry; go to DONE.
  - Otherwise stay in RUN.
- DONE:
  - busy=1, done=1 for exactly one cycle.
  - Next edge → IDLE unconditionally.

Timing:
- Latency: start accepted at edge k → busy high after edge k.
- done high in the cycle following edge k+WIDTH, i.e. WIDTH+1 edges after acceptance.
- Next start accepted at the earliest at edge k+WIDTH+2.
- Throughput: one addition per WIDTH+2 cycles.

Boundary conditions:
- start while busy (RUN or DONE): ignored. Operands in flight are unaffected. No queuing.
- start held high continuously: a new addition begins each time IDLE is reached, capturing the current a/b.
- a/b changing during RUN: no effect; operands were captured at start.
- sum/cout: hold their value from done until the next done or reset; they do not change during RUN.
- Wrap-around: the result is modulo 2^WIDTH; overflow is reported only via cout.
- WIDTH=1: RUN lasts exactly one edge. The count comparison is against 0.
- Count register width: max(1, clog2(WIDTH)).
- Reset mid-RUN or in DONE: returns to IDLE next edge with all outputs 0. No done pulse is produced for the aborted operation.

Test Plan:
- WIDTH=8, rst 2 cycles, then start with a=0x00, b=0x00 → busy=1 after 1 edge; done pulses on the 9th cycle after acceptance; sum=0x00, cout=0.
- WIDTH=8, a=0xFF, b=0x01 → full carry ripple; at done: sum=0x00, cout=1. A second run with a=0x80, b=0x80 gives sum=0x00, cout=1.
- WIDTH=8, a=0xA5, b=0x5A, then pulse start again mid-RUN with a=0x01, b=0x01 → second start ignored; done once with sum=0xFF, cout=0; busy falls the cycle after done.
- WIDTH=8, start held high for 30 cycles with a=0x12, b=0x34 → done every 10 cycles; each time sum=0x46, cout=0; sum stable between pulses.
- WIDTH=8, a=0x7F, b=0x01, assert rst at the 4th RUN cycle → next cycle busy=0, done=0, sum=0x00, cout=0. No done pulse follows. A fresh start then yields sum=0x80, cout=0.
- WIDTH=1, a=1, b=1 → done 2 edges after acceptance; sum=0, cout=1. Next run with a=1, b=0 gives sum=1, cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one shared full-add datapath (two half adders + OR)
// sequenced LSB first, with a registered result and a one-cycle done pulse.

module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b;
    assign o_cout = i_a & i_b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [CW-1:0]    r_count;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_ha1_sum;
    logic             w_ha1_cout;
    logic             w_ha2_sum;
    logic             w_ha2_cout;
    logic             w_bit_sum;
    logic             w_bit_carry;
    logic [WIDTH-1:0] w_res_next;

    half_adder u_ha1 (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .o_sum  (w_ha1_sum),
        .o_cout (w_ha1_cout)
    );

    half_adder u_ha2 (
        .i_a    (w_ha1_sum),
        .i_b    (r_carry),
        .o_sum  (w_ha2_sum),
        .o_cout (w_ha2_cout)
    );

    assign w_bit_sum   = w_ha2_sum;
    assign w_bit_carry = w_ha1_cout | w_ha2_cout;

    // The new bit enters at the MSB, so after WIDTH shifts bit 0 holds the LSB.
    generate
        if (WIDTH == 1) begin : g_res_one
            assign w_res_next = w_bit_sum;
        end else begin : g_res_many
            assign w_res_next = {w_bit_sum, r_res_sh[WIDTH-1:1]};
        end
    endgenerate

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others, exactly like real flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_count  <= '0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_carry  <= 1'b0;
                        r_count  <= '0;
                        r_res_sh <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res_sh <= w_res_next;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= w_bit_carry;
                    r_count  <= r_count + CW'(1);
                    if (r_count == LAST_BIT) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_bit_carry;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1, using a
// directed vector table, hand-written corner sequences and randomized runs.

module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       busy1, done1, cout1;
    logic       sum1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit         use1;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_busy(input bit use1);
        return use1 ? busy1 : busy8;
    endfunction

    function automatic logic get_done(input bit use1);
        return use1 ? done1 : done8;
    endfunction

    function automatic logic get_cout(input bit use1);
        return use1 ? cout1 : cout8;
    endfunction

    function automatic logic [7:0] get_sum(input bit use1);
        return use1 ? {7'b0, sum1} : sum8;
    endfunction

    task automatic drive(input bit use1, input logic st, input logic [7:0] a, input logic [7:0] b);
        if (use1) begin
            start1 = st;
            a1     = a[0];
            b1     = b[0];
        end else begin
            start8 = st;
            a8     = a;
            b8     = b;
        end
    endtask

    // One complete addition from IDLE: checks busy after acceptance, sum/cout
    // holding during RUN, done latency, result, and the return to IDLE.
    task automatic run_add(input bit use1, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_sum, input logic exp_cout, input string tag);
        int         w;
        int         got;
        logic [7:0] held_s;
        logic       held_c;
        logic [7:0] junk;
        w      = use1 ? 1 : 8;
        got    = 0;
        held_s = get_sum(use1);
        held_c = get_cout(use1);
        drive(use1, 1'b1, a, b);
        for (int n = 1; n <= w + 6 && got == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check({tag, " busy_after_accept"}, 32'(get_busy(use1)), 32'd1);
                junk = 8'($urandom);
                drive(use1, 1'b0, ~a, junk);
            end
            if (get_done(use1)) begin
                got = n;
            end else begin
                check({tag, " sum_hold"}, 32'(get_sum(use1)), 32'(held_s));
                check({tag, " cout_hold"}, 32'(get_cout(use1)), 32'(held_c));
            end
        end
        check({tag, " done_latency"}, 32'(got), 32'(w + 1));
        check({tag, " sum"}, 32'(get_sum(use1)), 32'(exp_sum));
        check({tag, " cout"}, 32'(get_cout(use1)), 32'(exp_cout));
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(get_done(use1)), 32'd0);
        check({tag, " busy_cleared"}, 32'(get_busy(use1)), 32'd0);
    endtask

    initial begin
        int         ndone;
        int         last_done;
        logic [7:0] ra, rb;
        logic [8:0] tot9;
        logic [1:0] tot2;

        vecs[0] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0};
        vecs[4] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0};
        vecs[5] = '{1'b0, 8'hC8, 8'h64, 8'h2C, 1'b1};
        vecs[6] = '{1'b0, 8'h0F, 8'hF1, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 8'h7F, 8'h7F, 8'hFE, 1'b0};
        vecs[8] = '{1'b1, 8'h01, 8'h01, 8'h00, 1'b1};
        vecs[9] = '{1'b1, 8'h01, 8'h00, 8'h01, 1'b0};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset busy8", 32'(busy8), 32'd0);
        check("reset done8", 32'(done8), 32'd0);
        check("reset sum8", 32'(sum8), 32'd0);
        check("reset cout8", 32'(cout8), 32'd0);
        check("reset busy1", 32'(busy1), 32'd0);
        check("reset sum1", 32'(sum1), 32'd0);
        check("reset cout1", 32'(cout1), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_add(vecs[i].use1, vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_cout,
                    $sformatf("vec%0d", i));
        end

        // Second start pulsed mid-RUN must be ignored.
        ndone = 0;
        drive(1'b0, 1'b1, 8'hA5, 8'h5A);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) drive(1'b0, 1'b0, 8'hA5, 8'h5A);
            if (n == 3) drive(1'b0, 1'b1, 8'h01, 8'h01);
            if (n == 4) drive(1'b0, 1'b0, 8'h01, 8'h01);
            if (done8) begin
                ndone++;
                check("midstart latency", 32'(n), 32'd9);
                check("midstart sum", 32'(sum8), 32'hFF);
                check("midstart cout", 32'(cout8), 32'd0);
            end
            if (n == 10) check("midstart busy_fall", 32'(busy8), 32'd0);
        end
        check("midstart done_count", 32'(ndone), 32'd1);

        // Start held high: back-to-back additions every WIDTH+2 cycles.
        ndone     = 0;
        last_done = 0;
        drive(1'b0, 1'b1, 8'h12, 8'h34);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done8) begin
                ndone++;
                if (last_done > 0) check("hold period", 32'(n - last_done), 32'd10);
                last_done = n;
                check("hold sum", 32'(sum8), 32'h46);
                check("hold cout", 32'(cout8), 32'd0);
            end else if (last_done > 0) begin
                check("hold sum_stable", 32'(sum8), 32'h46);
            end
        end
        drive(1'b0, 1'b0, 8'h12, 8'h34);
        check("hold done_count", 32'(ndone), 32'd3);
        check("hold first_done", 32'(ndone > 0 ? (last_done - 10 * (ndone - 1)) : 0), 32'd9);
        repeat (2) @(negedge clk);
        check("hold idle_after", 32'(busy8), 32'd0);

        // Reset in the 4th RUN cycle aborts the operation without a done pulse.
        ndone = 0;
        drive(1'b0, 1'b1, 8'h7F, 8'h01);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) drive(1'b0, 1'b0, 8'h7F, 8'h01);
        end
        check("abort busy_before", 32'(busy8), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy8), 32'd0);
        check("abort done", 32'(done8), 32'd0);
        check("abort sum", 32'(sum8), 32'd0);
        check("abort cout", 32'(cout8), 32'd0);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("abort no_done", 32'(ndone), 32'd0);
        run_add(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, "after_abort");

        // Randomized runs against plain-arithmetic expectations.
        for (int i = 0; i < 40; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            tot9 = {1'b0, ra} + {1'b0, rb};
            run_add(1'b0, ra, rb, tot9[7:0], tot9[8], $sformatf("rnd8_%0d", i));
        end
        for (int i = 0; i < 20; i++) begin
            ra   = 8'($urandom_range(0, 1));
            rb   = 8'($urandom_range(0, 1));
            tot2 = {1'b0, ra[0]} + {1'b0, rb[0]};
            run_add(1'b1, ra, rb, {7'b0, tot2[0]}, tot2[1], $sformatf("rnd1_%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
